sync_fifo_ex: RTL
=================

Name: sync_fifo_ex

Overview:
Parametrised single-clock FIFO for the scaler datapath: line and pixel buffering between stages that share one clock.
- Generalises the existing dual-clock FIFO with a selectable first-word-fall-through (FWFT) mode, an occupancy count, fixed and programmable almost-full/almost-empty thresholds, overflow/underflow pulses and a synchronous flush.
- Sits between the pixel interpolator and the output packer, and anywhere a same-clock elastic buffer is needed.

Parameters:
data_width, 16, word width in bits.
addr_width, 8, RAM address width; depth = 2**addr_width (localparam).
fwft, 0, 0 = standard read (registered dout one cycle after rd_en); 1 = first-word-fall-through.
prog_full_thresh, 240, prog_full asserts when count >= this value; legal range 1..depth.
prog_empty_thresh, 16, prog_empty asserts when count <= this value; legal range 0..depth-1.

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of contents; has priority over wr_en and rd_en.
wr_en  in  1  write request.
din  in  data_width  write data.
rd_en  in  1  read request (standard mode) / head acknowledge (FWFT mode).
dout  out  data_width  read data.
valid  out  1  dout holds a valid word.
empty  out  1  no readable word.
full  out  1  count == depth.
almost_full  out  1  count >= depth-1.
almost_empty  out  1  count <= 1.
prog_full  out  1  count >= prog_full_thresh.
prog_empty  out  1  count <= prog_empty_thresh.
data_count  out  addr_width+1  words held; in FWFT mode this includes the output register.
overflow  out  1  one-cycle pulse: write attempted while full.
underflow  out  1  one-cycle pulse: read attempted while empty.

Behaviour:
Reset (rst = 1, asynchronous):
- Pointers, count, dout, valid, overflow and underflow clear to 0.
- empty, almost_empty and prog_empty are 1; full, almost_full and prog_full are 0.
- RAM contents are not reset.

Flags and count:
- A registered count (addr_width+1 bits) is the single source for all flags.
- Flags are combinational decodes of that register, so they update after the same edge that changes count.
- Capacity is exactly depth words in both modes.

Write path:
- Accepted when wr_en && !full, sampled before the edge. The word is stored at wr_ptr and wr_ptr wraps mod depth.
- wr_en && full: write dropped, state unchanged, overflow = 1 for the following cycle.

Standard mode (fwft = 0):
- Read accepted when rd_en && !empty (empty = count == 0).
- After the edge: dout = mem[rd_ptr], valid = 1.
- On any cycle without an accepted read: dout = 0, valid = 0.
- Read latency is 1 cycle.

FWFT mode (fwft = 1):
- An output register prefetches the head word from the RAM. dout holds the head and valid = 1 whenever the FIFO is non-empty; empty = !valid.
- rd_en with valid = 1 pops the head. If the RAM holds a further word, it appears on dout at the same edge (no bubble).
- A write into a completely empty FIFO at edge N: valid and dout update after edge N+1. count increments at edge N.
- While valid = 0, dout holds its last value (do not zero it).

Simultaneous and boundary cases:
- Read and write in the same cycle: each is judged on pre-edge flags; count = count + wr_ok - rd_ok.
- When full: the read is accepted and the write is dropped (overflow pulse).
- When empty: the write is accepted and the read is rejected (underflow pulse). There is no write-to-read bypass.
- Pointer wrap from depth-1 to 0 is seamless; a full-then-drain cycle must return exactly depth words in order.
- underflow pulse: rd_en && empty.

Flush:
- Next state equals the reset state, except overflow and underflow are 0.
- wr_en and rd_en in the flush cycle are ignored and produce no overflow/underflow pulse.
- rst asserted mid-transfer aborts immediately; no partial word is presented after release.

Decomposition:
Shared package/header fifo_pkg:
- Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- Count-width function clog2-style.
- Elaboration-time threshold range checks.

Sub-module sdp_ram:
- Simple dual-port RAM: one write port, one read port registered on clk.
- No reset.
- Infers block RAM.

Test Plan (addr_width = 3 so depth = 8, prog_full_thresh = 6, prog_empty_thresh = 2, data_width = 16):
1. Std mode: write 0x0001..0x0008 on consecutive cycles -> full = 1, data_count = 8, prog_full asserted from count 6. A 9th write of 0x0009 -> overflow pulses 1 cycle and count stays 8. Reading 8 times -> dout 0x0001..0x0008, each one cycle after its rd_en, valid high for exactly 8 cycles.
2. Std mode: rd_en with FIFO empty -> underflow pulses 1 cycle, dout = 0, valid = 0. Write 0x00AA and read in the same cycle when empty -> read rejected, count = 1.
3. Full FIFO: wr_en and rd_en together -> head read out, write dropped with overflow = 1, count = 7. Repeat at count 4 -> count stays 4 and order is preserved.
4. FWFT mode: write 0x1234 at edge N -> valid = 1, dout = 0x1234 after edge N+1. Continuous reads of a 5-word burst -> no bubble between words.
5. Wrap: 3 passes of fill-8 / drain-8 with incrementing data -> 24 words out in order, no loss or duplication, flags match a reference count model.
6. Flush with count = 5 and wr_en = rd_en = 1 -> count 0, empty = 1, valid = 0, no overflow/underflow pulse. Async rst mid-burst -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: mode constants, count sizing
// and threshold legality used at elaboration.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to hold the values 0..depth inclusive.
    function automatic int count_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) <= depth) w++;
        return w;
    endfunction

    function automatic bit thresholds_legal(input int depth, input int pf, input int pe);
        return (pf >= 1) && (pf <= depth) && (pe >= 0) && (pe <= depth - 1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram #(
    parameter int data_width = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [2**addr_width];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_ex.sv
// Single-clock FIFO with optional first-word-fall-through, occupancy count,
// fixed/programmable thresholds, overflow/underflow pulses and flush.
module sync_fifo_ex
    import fifo_pkg::*;
#(
    parameter int data_width        = 16,
    parameter int addr_width        = 8,
    parameter int fwft              = FIFO_MODE_STD,
    parameter int prog_full_thresh  = 240,
    parameter int prog_empty_thresh = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [data_width-1:0] din,
    input  logic                  rd_en,
    output logic [data_width-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [addr_width:0]   data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int depth = 2 ** addr_width;
    localparam int cw    = addr_width + 1;
    localparam logic [addr_width:0] depth_c = cw'(depth);
    localparam logic [addr_width:0] pf_c    = cw'(prog_full_thresh);
    localparam logic [addr_width:0] pe_c    = cw'(prog_empty_thresh);

    if (!thresholds_legal(depth, prog_full_thresh, prog_empty_thresh)) begin : g_bad_thresh
        $error("sync_fifo_ex: programmable threshold out of range");
    end
    if (count_width(depth) != cw) begin : g_bad_width
        $error("sync_fifo_ex: count width does not cover depth");
    end

    logic [addr_width-1:0] wr_ptr, rd_ptr;
    logic [addr_width:0]   count, count_nxt, ram_cnt;
    logic                  valid_r, valid_nxt, primed;
    logic                  wr_ok, rd_ok, load, ren;
    logic [data_width-1:0] ram_q;

    // In FWFT mode the RAM read register doubles as the output register;
    // ram_cnt is the number of words still waiting behind it.
    always_comb begin
        wr_ok     = wr_en && !full && !flush;
        rd_ok     = rd_en && !empty && !flush;
        ram_cnt   = count - {{addr_width{1'b0}}, valid_r};
        load      = 1'b0;
        valid_nxt = rd_ok;
        ren       = rd_ok;
        if (fwft == FIFO_MODE_FWFT) begin
            load      = !flush && (!valid_r || rd_ok) && (ram_cnt != '0);
            valid_nxt = load || (valid_r && !rd_ok);
            ren       = load;
        end
        count_nxt = count + {{addr_width{1'b0}}, wr_ok} - {{addr_width{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_r   <= 1'b0;
            primed    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_r   <= 1'b0;
            primed    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (ren) begin
                rd_ptr <= rd_ptr + 1'b1;
                primed <= 1'b1;
            end
            count     <= count_nxt;
            valid_r   <= valid_nxt;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    sdp_ram #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ren),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Gating keeps dout at zero after reset/flush, since the RAM register is not reset.
    assign dout         = ((fwft == FIFO_MODE_FWFT) ? primed : valid_r) ? ram_q : '0;
    assign valid        = valid_r;
    assign empty        = (fwft == FIFO_MODE_FWFT) ? !valid_r : (count == '0);
    assign full         = (count == depth_c);
    assign almost_full  = (count >= depth_c - 1'b1);
    assign almost_empty = (count <= cw'(1));
    assign prog_full    = (count >= pf_c);
    assign prog_empty   = (count <= pe_c);
    assign data_count   = count;

endmodule
